// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master/slave pair.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slave_state_t;

  function automatic int spi_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_synchronizer.sv
// Single-bit multi-flop synchroniser for asynchronous SPI pin inputs.
module spi_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], i_async};

  // Clearing to 0 makes a CS_n still held low after reset look already asserted,
  // so only a fresh high->low transition can start a transfer.
  always_ff @(posedge i_clock) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/MOSI/CS_n, all four CPOL/CPHA modes, MSB-first,
// back-to-back words while CS_n stays low.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clock_polarity,
  input  logic                      i_clock_phase,
  input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
  input  logic                      i_tx_load,
  output logic                      o_tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_rx_valid,
  output logic                      o_busy,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_clock,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe
);

  localparam int W  = SPI_DATA_WIDTH;
  localparam int CW = spi_cnt_width(SPI_DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic cs_s, sclk_s, mosi_s;
  logic cs_dly_q, cs_dly_d, sclk_dly_q, sclk_dly_d;
  spi_slave_state_t state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [W-1:0]  hold_q, hold_d, rx_data_q, rx_data_d, reload_word;
  logic hold_full_q, hold_full_d, skip_q, skip_d, word_done_q, word_done_d;
  logic rx_valid_q, rx_valid_d, busy_q, busy_d, miso_q, miso_d, oe_q, oe_d;
  logic reload, sclk_toggle, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  spi_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_cs_n), .o_sync(cs_s));
  spi_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_clock), .o_sync(sclk_s));
  spi_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_mosi), .o_sync(mosi_s));

  assign sclk_toggle = sclk_s ^ sclk_dly_q;
  assign lead_edge   = sclk_toggle & (sclk_s != mode_q.cpol);
  assign trail_edge  = sclk_toggle & (sclk_s == mode_q.cpol);
  assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_q.cpha ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & cs_dly_q;
  assign cs_rise     = cs_s & ~cs_dly_q;
  assign reload_word = hold_full_q ? hold_q : '0;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    skip_d      = skip_q;
    word_done_d = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    reload      = 1'b0;
    cs_dly_d    = cs_s;
    sclk_dly_d  = sclk_s;

    if (word_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          mode_d  = '{cpol: i_clock_polarity, cpha: i_clock_phase};
          reload  = 1'b1;
          cnt_d   = '0;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          // With CPHA=1 the MSB waits for the first leading edge.
          skip_d  = i_clock_phase;
          miso_d  = i_clock_phase ? 1'b0 : reload_word[W-1];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          oe_d        = 1'b0;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
          skip_d      = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[W-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            cnt_d       = '0;
            word_done_d = 1'b1;
            reload      = 1'b1;
            // The next shift edge must not consume the freshly reloaded MSB.
            skip_d      = 1'b1;
            if (!mode_q.cpha) miso_d = reload_word[W-1];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (shift_edge) begin
          if (skip_q) begin
            skip_d = 1'b0;
            if (mode_q.cpha) miso_d = tx_shift_q[W-1];
          end else begin
            tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
            miso_d     = tx_shift_q[W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load coinciding with a reload: reload takes the old word, new word stays held.
    if (reload) begin
      tx_shift_d  = reload_word;
      hold_full_d = 1'b0;
    end
    if (i_tx_load) begin
      hold_d      = i_tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      skip_q      <= 1'b0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cs_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      skip_q      <= skip_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cs_dly_q    <= cs_dly_d;
      sclk_dly_q  <= sclk_dly_d;
    end
  end

  assign o_tx_ready    = ~hold_full_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_busy        = busy_q;
  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench acts as SPI master; received words go through an expected-value queue
// that a separate monitor drains on every o_rx_valid pulse.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_clock_polarity = 1'b0, i_clock_phase = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_load = 1'b0;
  logic       o_tx_ready, o_rx_valid, o_busy, o_spi_miso, o_spi_miso_oe;
  logic [7:0] o_rx_data;
  logic       i_spi_cs_n = 1'b1, i_spi_clock = 1'b0, i_spi_mosi = 1'b0;

  int n_cmp = 0, n_fail = 0, n_pushed = 0, n_pulses = 0;
  logic [7:0] exp_q[$];
  logic cpol_r = 1'b0, cpha_r = 1'b0;
  logic [7:0] s;

  spi_slave #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_clock_polarity(i_clock_polarity), .i_clock_phase(i_clock_phase),
    .i_tx_data(i_tx_data), .i_tx_load(i_tx_load), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
    .i_spi_cs_n(i_spi_cs_n), .i_spi_clock(i_spi_clock), .i_spi_mosi(i_spi_mosi),
    .o_spi_miso(o_spi_miso), .o_spi_miso_oe(o_spi_miso_oe));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rx pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_rx_valid) begin
      n_pulses++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got %h expected no pulse", o_rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_word: got %h expected %h", o_rx_data, e);
        end
      end
    end
  end

  task automatic push_rx(input logic [7:0] v);
    exp_q.push_back(v);
    n_pushed++;
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk); i_tx_load = 1'b1; i_tx_data = v;
    @(negedge clk); i_tx_load = 1'b0;
  endtask

  // Half SCLK period (5 clocks); optionally pulses i_tx_load in the cycle the
  // slave applies a sampling-edge word boundary.
  task automatic wait_half(input bit ld, input logic [7:0] v);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ld && k == 1) begin i_tx_load = 1'b1; i_tx_data = v; end
      else i_tx_load = 1'b0;
    end
  endtask

  task automatic begin_xfer(input logic cpol, input logic cpha);
    @(negedge clk);
    cpol_r = cpol; cpha_r = cpha;
    i_clock_polarity = cpol; i_clock_phase = cpha;
    i_spi_clock = cpol; i_spi_mosi = 1'b0;
    repeat (2) @(negedge clk);
    i_spi_cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic end_xfer();
    repeat (5) @(negedge clk);
    i_spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_bit(input logic mb, input bit ld, input logic [7:0] ldv, output logic sb);
    if (!cpha_r) begin
      i_spi_mosi = mb;
      wait_half(0, 8'h00);
      sb = o_spi_miso;
      i_spi_clock = ~cpol_r;
      wait_half(ld, ldv);
      i_spi_clock = cpol_r;
    end else begin
      i_spi_clock = ~cpol_r;
      i_spi_mosi = mb;
      wait_half(0, 8'h00);
      sb = o_spi_miso;
      i_spi_clock = cpol_r;
      wait_half(ld, ldv);
    end
  endtask

  task automatic send_word(input logic [7:0] m, input bit ld, input logic [7:0] ldv,
                           output logic [7:0] sw);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      do_bit(m[i], ld && (i == 0), ldv, b);
      sw[i] = b;
    end
  endtask

  initial begin
    logic b;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("reset_rx_data", o_rx_data, 8'h00);
    check("reset_rx_valid", o_rx_valid, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_miso", o_spi_miso, 1'b0);
    check("reset_miso_oe", o_spi_miso_oe, 1'b0);
    check("reset_tx_ready", o_tx_ready, 1'b1);

    // Mode 0 single word
    load_tx(8'h3C);
    check("m0_ready_after_load", o_tx_ready, 1'b0);
    begin_xfer(1'b0, 1'b0);
    check("m0_ready_after_cs", o_tx_ready, 1'b1);
    check("m0_busy", o_busy, 1'b1);
    check("m0_oe", o_spi_miso_oe, 1'b1);
    push_rx(8'hA5);
    send_word(8'hA5, 0, 8'h00, s);
    check("m0_master_rx", s, 8'h3C);
    end_xfer();
    check("m0_idle_oe", o_spi_miso_oe, 1'b0);
    check("m0_idle_busy", o_busy, 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      load_tx(8'hC3);
      begin_xfer(m[1], m[0]);
      push_rx(8'h5A);
      send_word(8'h5A, 0, 8'h00, s);
      check($sformatf("mode%0d_master_rx", m), s, 8'hC3);
      end_xfer();
      check($sformatf("mode%0d_idle_oe", m), o_spi_miso_oe, 1'b0);
      check($sformatf("mode%0d_idle_miso", m), o_spi_miso, 1'b0);
    end

    // Back-to-back, three words under one CS_n
    load_tx(8'h11);
    begin_xfer(1'b0, 1'b0);
    load_tx(8'h22);
    push_rx(8'h01); send_word(8'h01, 0, 8'h00, s); check("b2b_w1", s, 8'h11);
    push_rx(8'h02); send_word(8'h02, 0, 8'h00, s); check("b2b_w2", s, 8'h22);
    push_rx(8'h03); send_word(8'h03, 0, 8'h00, s); check("b2b_w3_empty", s, 8'h00);
    end_xfer();

    // Load coincident with the word-boundary reload
    load_tx(8'h55);
    begin_xfer(1'b0, 1'b0);
    load_tx(8'h77);
    push_rx(8'h10); send_word(8'h10, 1, 8'h99, s); check("sim_w1", s, 8'h55);
    check("sim_ready_stays_0", o_tx_ready, 1'b0);
    push_rx(8'h20); send_word(8'h20, 0, 8'h00, s); check("sim_w2_old", s, 8'h77);
    push_rx(8'h30); send_word(8'h30, 0, 8'h00, s); check("sim_w3_new", s, 8'h99);
    end_xfer();

    // Abort after 5 bits
    begin_xfer(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_bit(1'b1, 0, 8'h00, b);
    end_xfer();
    check("abort_rx_data_kept", o_rx_data, 8'h30);
    check("abort_busy", o_busy, 1'b0);
    begin_xfer(1'b0, 1'b0);
    push_rx(8'hFF);
    send_word(8'hFF, 0, 8'h00, s);
    check("after_abort_master_rx", s, 8'h00);
    end_xfer();

    // Reset at bit 3 with CS_n held low
    load_tx(8'hAA);
    begin_xfer(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_bit(1'b1, 0, 8'h00, b);
    @(negedge clk); i_reset = 1'b1;
    repeat (2) @(negedge clk); i_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_oe", o_spi_miso_oe, 1'b0);
    check("rst_miso", o_spi_miso, 1'b0);
    check("rst_tx_ready", o_tx_ready, 1'b1);
    send_word(8'hE7, 0, 8'h00, s);
    check("rst_no_start_busy", o_busy, 1'b0);
    check("rst_no_start_rx_data", o_rx_data, 8'h00);
    end_xfer();
    begin_xfer(1'b0, 1'b0);
    check("rst_fresh_busy", o_busy, 1'b1);
    push_rx(8'h6B);
    send_word(8'h6B, 0, 8'h00, s);
    check("rst_fresh_master_rx", s, 8'h00);
    end_xfer();

    repeat (20) @(negedge clk);
    check("rx_leftover", exp_q.size(), 0);
    check("rx_pulse_count", n_pulses, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
